// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter
// Shares one AXI AR/R channel pair between an instruction-fetch requester
// and a data-load requester, both using sram-like handshakes.
//
// Ports:
//   clk, rst_p                 clock, asynchronous active-high reset
//   inst_req/addr              instruction read request
//   inst_addr_ok/data_ok/rdata instruction accept, data valid, data
//   data_req/addr/size         data read request
//   data_addr_ok/data_ok/rdata data accept, data valid, data
//   write_pending              blocks new data grants while a store is in flight
//   arid/araddr/arsize/arvalid/arready  AXI read address channel
//   rid/rdata/rlast/rvalid/rready       AXI read data channel
//
// Data has priority. Once STARVE_LIMIT data grants have gone by while inst
// was waiting, inst gets the next grant. Each requester may have at most
// MAX_OUTSTANDING reads in flight. R beats are steered by rid (0 = inst,
// 1 = data). Only single-beat bursts are expected.
module axi_read_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        rst_p,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [2:0]  data_size,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  input  logic        write_pending,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic {IDLE, AR_WAIT} state_t;

  state_t         r_state;
  logic           r_arvalid;
  logic [3:0]     r_arid;
  logic [31:0]    r_araddr;
  logic [2:0]     r_arsize;
  logic [2:0]     r_inst_cnt;
  logic [2:0]     r_data_cnt;
  logic [SW-1:0]  r_starve;

  logic w_idle;
  logic w_inst_elig;
  logic w_data_elig;
  logic w_starved;
  logic w_grant_inst;
  logic w_grant_data;
  logic w_inst_beat;
  logic w_data_beat;
  logic w_unused_rlast;

  // Bursts are single-beat, so rlast carries no extra information.
  assign w_unused_rlast = rlast;

  assign w_idle      = (r_state == IDLE) && !rst_p;
  assign w_inst_elig = inst_req && (r_inst_cnt < 3'(MAX_OUTSTANDING));
  assign w_data_elig = data_req && !write_pending && (r_data_cnt < 3'(MAX_OUTSTANDING));
  assign w_starved   = (r_starve == SW'(STARVE_LIMIT)) && w_inst_elig;

  assign w_grant_data = w_idle && w_data_elig && !w_starved;
  assign w_grant_inst = w_idle && w_inst_elig && !w_grant_data;

  assign inst_addr_ok = w_grant_inst;
  assign data_addr_ok = w_grant_data;

  // R channel never backpressures; it only closes while reset is held.
  assign rready = !rst_p;

  // IDs outside {0,1} fall through both compares and are dropped.
  assign w_inst_beat = rvalid && rready && (rid == 4'd0);
  assign w_data_beat = rvalid && rready && (rid == 4'd1);

  assign inst_data_ok = w_inst_beat;
  assign data_data_ok = w_data_beat;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  assign arvalid = r_arvalid;
  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arsize  = r_arsize;

  // Simultaneous capture and return cancel out; a return with nothing
  // outstanding leaves the count at zero.
  function automatic logic [2:0] next_cnt(input logic [2:0] cnt,
                                          input logic inc,
                                          input logic dec);
    logic [2:0] res;
    res = cnt;
    if (inc && !dec)
      res = cnt + 3'd1;
    else if (dec && !inc && (cnt != 3'd0))
      res = cnt - 3'd1;
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      r_state    <= IDLE;
      r_arvalid  <= 1'b0;
      r_arid     <= 4'd0;
      r_araddr   <= 32'd0;
      r_arsize   <= 3'd0;
      r_inst_cnt <= 3'd0;
      r_data_cnt <= 3'd0;
      r_starve   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_data || w_grant_inst) begin
            r_state   <= AR_WAIT;
            r_arvalid <= 1'b1;
            r_arid    <= w_grant_data ? 4'd1 : 4'd0;
            r_araddr  <= w_grant_data ? data_addr : inst_addr;
            r_arsize  <= w_grant_data ? data_size : 3'd2;
          end
        end
        AR_WAIT: begin
          if (arready) begin
            r_state   <= IDLE;
            r_arvalid <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_arvalid <= 1'b0;
        end
      endcase

      r_inst_cnt <= next_cnt(r_inst_cnt, w_grant_inst, w_inst_beat);
      r_data_cnt <= next_cnt(r_data_cnt, w_grant_data, w_data_beat);

      // Counts data grants that overtook a waiting inst request.
      if (!inst_req || w_grant_inst)
        r_starve <= '0;
      else if (w_grant_data && (r_starve != SW'(STARVE_LIMIT)))
        r_starve <= r_starve + SW'(1);
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed testbench for axi_read_arbiter with default parameters
// (MAX_OUTSTANDING = 2, STARVE_LIMIT = 4).
module tb_axi_read_arbiter;

  logic        clk;
  logic        rst_p;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [31:0] data_addr;
  logic [2:0]  data_size;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        write_pending;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int vectors;
  int miscompares;

  axi_read_arbiter #(
    .MAX_OUTSTANDING(2),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst_p(rst_p),
    .inst_req(inst_req),
    .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req),
    .data_addr(data_addr),
    .data_size(data_size),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .write_pending(write_pending),
    .arid(arid),
    .araddr(araddr),
    .arsize(arsize),
    .arvalid(arvalid),
    .arready(arready),
    .rid(rid),
    .rdata(rdata),
    .rlast(rlast),
    .rvalid(rvalid),
    .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idleInputs();
    inst_req      = 1'b0;
    inst_addr     = 32'd0;
    data_req      = 1'b0;
    data_addr     = 32'd0;
    data_size     = 3'd0;
    write_pending = 1'b0;
    arready       = 1'b0;
    rid           = 4'd0;
    rdata         = 32'd0;
    rlast         = 1'b1;
    rvalid        = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    idleInputs();
    rst_p = 1'b1;
    @(negedge clk);
    rst_p = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_p    = 1'b1;
    inst_req = 1'b1;
    data_req = 1'b1;
    rvalid   = 1'b1;
    rid      = 4'd0;
    rdata    = 32'h1111_2222;
    #1;
    vectors++;
    if ({arvalid, arid, araddr, arsize} !== 40'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_ar: got %h expected 0", {arvalid, arid, araddr, arsize});
    end
    vectors++;
    if ({rready, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_hs: got %b expected 00000",
               {rready, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
    end
    @(negedge clk);
    idleInputs();
    rst_p = 1'b0;
    #1;
    vectors++;
    if (rready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_rready: got %b expected 1", rready);
    end
  endtask

  // Both requesters saturate the channel; each AR is answered two cycles
  // after its handshake, so data never hits its outstanding limit.
  task automatic test_contention();
    logic       sv[0:39];
    logic [3:0] sid[0:39];
    logic [3:0] gseq[0:15];
    int nh, o0, o1, maxo;
    logic [3:0] expId;
    for (int i = 0; i < 40; i++) begin
      sv[i]  = 1'b0;
      sid[i] = 4'd0;
    end
    nh = 0; o0 = 0; o1 = 0; maxo = 0;
    doReset();
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      inst_req  = (c < 20);
      data_req  = (c < 20);
      inst_addr = 32'h0000_1000 + 32'(c) * 4;
      data_addr = 32'h0000_2000 + 32'(c) * 4;
      data_size = 3'd2;
      arready   = 1'b1;
      rvalid    = sv[c];
      rid       = sid[c];
      rdata     = 32'hA500_0000 + 32'(c);
      #1;
      if (rvalid) begin
        vectors++;
        if ({inst_data_ok, data_data_ok} !== ((rid == 4'd0) ? 2'b10 : 2'b01)) begin
          miscompares++;
          $display("[TB] FAIL steer_c%0d: got %b for rid %0d", c,
                   {inst_data_ok, data_data_ok}, rid);
        end
        if (rid == 4'd0) o0--; else o1--;
      end
      if (arvalid && arready) begin
        if (arid == 4'd0) o0++; else o1++;
        if (o0 > maxo) maxo = o0;
        if (o1 > maxo) maxo = o1;
        if (nh < 16) gseq[nh] = arid;
        nh++;
        sv[c+2]  = 1'b1;
        sid[c+2] = arid;
      end
    end
    vectors++;
    if (nh !== 10) begin
      miscompares++;
      $display("[TB] FAIL grant_count: got %0d expected 10", nh);
    end
    for (int k = 0; k < 10; k++) begin
      expId = ((k % 5) == 4) ? 4'd0 : 4'd1;
      vectors++;
      if (k >= nh || gseq[k] !== expId) begin
        miscompares++;
        $display("[TB] FAIL grant_seq_%0d: got %0d expected %0d", k,
                 (k < nh) ? gseq[k] : 4'hF, expId);
      end
    end
    vectors++;
    if (maxo > 2) begin
      miscompares++;
      $display("[TB] FAIL max_outstanding: got %0d expected <=2", maxo);
    end
  endtask

  task automatic test_ar_hold();
    int pulses, stable;
    pulses = 0; stable = 0;
    doReset();
    @(negedge clk);
    data_req  = 1'b1;
    data_addr = 32'h1234_5678;
    data_size = 3'd1;
    arready   = 1'b0;
    #1;
    pulses += int'(data_addr_ok);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      data_addr = 32'hDEAD_0000 + 32'(c);
      data_size = 3'd3;
      #1;
      pulses += int'(data_addr_ok);
      if (arvalid === 1'b1 && araddr === 32'h1234_5678 && arid === 4'd1 && arsize === 3'd1)
        stable++;
    end
    @(negedge clk);
    arready = 1'b1;
    #1;
    pulses += int'(data_addr_ok);
    @(negedge clk);
    data_req = 1'b0;
    arready  = 1'b0;
    #1;
    pulses += int'(data_addr_ok);
    vectors++;
    if (stable !== 5) begin
      miscompares++;
      $display("[TB] FAIL ar_stable: got %0d cycles expected 5", stable);
    end
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("[TB] FAIL addr_ok_pulses: got %0d expected 1", pulses);
    end
    vectors++;
    if (arvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ar_released: got %b expected 0", arvalid);
    end
  endtask

  task automatic test_inst_full();
    doReset();
    @(negedge clk);
    inst_req  = 1'b1;
    inst_addr = 32'h0000_0100;
    arready   = 1'b1;
    #1;
    vectors++;
    if (inst_addr_ok !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL full_first: got %b expected 1", inst_addr_ok);
    end
    @(negedge clk);
    @(negedge clk);
    inst_addr = 32'h0000_0104;
    @(negedge clk);
    @(negedge clk);
    #1;
    vectors++;
    if (inst_addr_ok !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_block: got %b expected 0", inst_addr_ok);
    end
    @(negedge clk);
    rvalid = 1'b1;
    rid    = 4'd0;
    rdata  = 32'hCAFE_F00D;
    #1;
    vectors++;
    if ({inst_data_ok, data_data_ok, inst_addr_ok} !== 3'b100 || inst_rdata !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("[TB] FAIL full_return: got ok=%b rdata=%h expected ok=100 rdata=cafef00d",
               {inst_data_ok, data_data_ok, inst_addr_ok}, inst_rdata);
    end
    @(negedge clk);
    rvalid = 1'b0;
    #1;
    vectors++;
    if (inst_addr_ok !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL full_regrant: got %b expected 1", inst_addr_ok);
    end
    @(negedge clk);
    inst_req = 1'b0;
    @(negedge clk);
    arready = 1'b0;
  endtask

  task automatic test_write_pending();
    doReset();
    @(negedge clk);
    write_pending = 1'b1;
    data_req      = 1'b1;
    inst_req      = 1'b1;
    data_addr     = 32'h0000_3000;
    data_size     = 3'd0;
    inst_addr     = 32'h0000_0400;
    arready       = 1'b1;
    #1;
    vectors++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL wp_hold: got %b expected 10", {inst_addr_ok, data_addr_ok});
    end
    @(negedge clk);
    write_pending = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL wp_release: got %b expected 01", {inst_addr_ok, data_addr_ok});
    end
    @(negedge clk);
    inst_req = 1'b0;
    data_req = 1'b0;
    #1;
    vectors++;
    if ({arvalid, arid, arsize, araddr} !== {1'b1, 4'd1, 3'd0, 32'h0000_3000}) begin
      miscompares++;
      $display("[TB] FAIL wp_ar: got %h expected %h", {arvalid, arid, arsize, araddr},
               {1'b1, 4'd1, 3'd0, 32'h0000_3000});
    end
    @(negedge clk);
    arready = 1'b0;
  endtask

  task automatic test_same_cycle();
    doReset();
    @(negedge clk);
    data_req  = 1'b1;
    data_addr = 32'h0000_4000;
    data_size = 3'd2;
    arready   = 1'b1;
    @(negedge clk);
    data_req = 1'b0;
    @(negedge clk);
    data_req = 1'b1;
    rvalid   = 1'b1;
    rid      = 4'd1;
    rdata    = 32'h5555_AAAA;
    #1;
    vectors++;
    if ({data_addr_ok, data_data_ok, inst_data_ok} !== 3'b110 || data_rdata !== 32'h5555_AAAA) begin
      miscompares++;
      $display("[TB] FAIL same_cycle: got ok=%b rdata=%h expected ok=110 rdata=5555aaaa",
               {data_addr_ok, data_data_ok, inst_data_ok}, data_rdata);
    end
    @(negedge clk);
    data_req = 1'b0;
    rvalid   = 1'b0;
    @(negedge clk);
    data_req = 1'b1;
    #1;
    vectors++;
    if (data_addr_ok !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL cnt_one_grant: got %b expected 1", data_addr_ok);
    end
    @(negedge clk);
    data_req = 1'b0;
    @(negedge clk);
    data_req = 1'b1;
    rvalid   = 1'b1;
    rid      = 4'd5;
    #1;
    vectors++;
    if ({data_addr_ok, inst_data_ok, data_data_ok} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL bad_rid: got %b expected 000",
               {data_addr_ok, inst_data_ok, data_data_ok});
    end
    @(negedge clk);
    rvalid = 1'b0;
    #1;
    vectors++;
    if (data_addr_ok !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bad_rid_cnt: got %b expected 0", data_addr_ok);
    end
    data_req = 1'b0;
    arready  = 1'b0;
  endtask

  task automatic test_reset_mid();
    int quiet;
    quiet = 0;
    doReset();
    @(negedge clk);
    data_req  = 1'b1;
    data_addr = 32'h0000_5000;
    arready   = 1'b0;
    @(negedge clk);
    data_req = 1'b0;
    #1;
    vectors++;
    if (arvalid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_wait: got %b expected 1", arvalid);
    end
    #1;
    rst_p = 1'b1;
    #1;
    vectors++;
    if ({arvalid, rready} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: got %b expected 00", {arvalid, rready});
    end
    @(negedge clk);
    rst_p = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      if (arvalid === 1'b0 && data_addr_ok === 1'b0 && rready === 1'b1) quiet++;
    end
    vectors++;
    if (quiet !== 3) begin
      miscompares++;
      $display("[TB] FAIL post_reset_quiet: got %0d cycles expected 3", quiet);
    end
    @(negedge clk);
    data_req = 1'b1;
    #1;
    vectors++;
    if (data_addr_ok !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL post_reset_grant: got %b expected 1", data_addr_ok);
    end
    @(negedge clk);
    data_req = 1'b0;
    arready  = 1'b1;
    @(negedge clk);
    arready = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_p       = 1'b1;
    idleInputs();
    test_reset();
    test_contention();
    test_ar_hold();
    test_inst_full();
    test_write_pending();
    test_same_cycle();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
